// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default constants for the instruction-fetch front end
package fetch_pkg;
    localparam int XLEN_DEF = 32;
    localparam int PC_STEP_DEF = 4;
    localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = '0;
    typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_e;
    typedef struct packed {
        logic [XLEN_DEF-1:0] inst;
        logic [XLEN_DEF-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO with wrap-bit pointers, flush and a zeroed head when empty
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic full;
    assign count = wr_q - rd_q;
    assign empty = wr_q == rd_q;
    assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout = empty ? '0 : mem_q[rd_q[AW-1:0]];
    always_comb begin
        mem_d = mem_q;
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q[AW-1:0]] = din;
                wr_d = wr_q + PW'(1);
            end
            if (pop) rd_d = rd_q + PW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) mem_q <= mem_d;
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset) (push && !flush) |-> (!full || pop));
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC owner, single-outstanding imem fetch FSM and decode-side instruction queue
module fetch_queue import fetch_pkg::*; #(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int              PC_STEP  = PC_STEP_DEF
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    output logic [XLEN-1:0] Pc,
    output logic            Ready
);
    localparam int CW = $clog2(DEPTH) + 1;
    fetch_state_e state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, req_addr_q, req_addr_d;
    logic [CW-1:0] count;
    logic [2*XLEN-1:0] head;
    logic empty, pop, push, issue;
    assign pop = inst_valid && inst_ready;
    assign issue = reset && !redirect && state_q == IDLE && (count - CW'(pop)) < CW'(DEPTH);
    assign imem_req = issue || state_q != IDLE;
    assign imem_addr = state_q == IDLE ? fetch_pc_q : req_addr_q;
    assign inst_valid = !empty;
    assign {inst, inst_pc} = head;
    assign Pc = fetch_pc_q;
    assign Ready = state_q == IDLE;
    always_comb begin
        state_d = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        push = 1'b0;
        if (issue) begin
            req_addr_d = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            push = imem_ack;
            if (!imem_ack) state_d = WAIT;
        end else if (state_q != IDLE && imem_ack) begin
            push = state_q == WAIT && !redirect;
            state_d = IDLE;
        end else if (state_q != IDLE && redirect) begin
            state_d = DROP;
        end
        if (redirect) fetch_pc_d = redirect_pc;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end
    fetch_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(2*XLEN)
    ) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .flush(redirect),
        .din({imem_rdata, imem_addr}),
        .dout(head),
        .count(count),
        .empty(empty)
    );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard monitor for the fetch front end
module tb_fetch_queue;
    import fetch_pkg::*;
    logic clk = 0, reset = 0, redirect = 0, inst_ready = 0, mem_en = 0;
    logic [31:0] redirect_pc = 0;
    logic imem_req, imem_ack, inst_valid, Ready;
    logic [31:0] imem_addr, imem_rdata, inst, inst_pc, Pc;
    int n_cmp = 0, n_bad = 0;
    int lat = 0, wait_cnt = 0, wait_nxt = 0, acks = 0, acks_nxt = 0, base = 0;
    fetch_entry_t exp_q[$];

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_ready(inst_ready), .Pc(Pc), .Ready(Ready)
    );

    // memory: acks once the request has been held for lat cycles
    assign imem_ack = mem_en && imem_req && wait_cnt == lat;
    assign imem_rdata = imem_addr ^ 32'hFFFF0000;
    always @(negedge clk) begin
        wait_nxt = (!reset || !imem_req || imem_ack) ? 0 : wait_cnt + 1;
        acks_nxt = acks + ((reset && imem_req && imem_ack) ? 1 : 0);
    end
    always @(posedge clk) begin
        wait_cnt <= wait_nxt;
        acks <= acks_nxt;
    end

    function automatic fetch_entry_t mk(input logic [31:0] pc);
        fetch_entry_t e;
        e.inst = pc ^ 32'hFFFF0000;
        e.pc = pc;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_unexpected: got pc %h expected no delivery", inst_pc);
            end else begin
                chk("pop_entry", {inst, inst_pc}, exp_q.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input string name);
        chk(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, 64'(imem_req), 64'd0);
        chk({tag, "_addr"}, 64'(imem_addr), 64'd0);
        chk({tag, "_valid"}, 64'(inst_valid), 64'd0);
        chk({tag, "_inst"}, 64'(inst), 64'd0);
        chk({tag, "_inst_pc"}, 64'(inst_pc), 64'd0);
        chk({tag, "_pc"}, 64'(Pc), 64'd0);
        chk({tag, "_ready"}, 64'(Ready), 64'd1);
    endtask

    task automatic do_reset;
        reset = 0;
        redirect = 0;
        inst_ready = 0;
        mem_en = 0;
        tick;
        tick;
        #1;
        chk_reset_vals("rst");
        reset = 1;
    endtask

    initial begin
        // zero-wait memory, decode always ready
        do_reset;
        lat = 0; mem_en = 1; inst_ready = 1;
        for (int k = 0; k < 8; k++) exp_q.push_back(mk(32'(4 * k)));
        #1;
        chk("t1_first_req", 64'(imem_req), 64'd1);
        chk("t1_first_addr", 64'(imem_addr), 64'd0);
        chk("t1_first_valid", 64'(inst_valid), 64'd0);
        tick; #1;
        chk("t1_c2_valid", 64'(inst_valid), 64'd1);
        chk("t1_c2_inst_pc", 64'(inst_pc), 64'd0);
        chk("t1_c2_addr", 64'(imem_addr), 64'd4);
        chk("t1_c2_pc", 64'(Pc), 64'd4);
        repeat (6) begin
            tick; #1;
            chk("t1_ready", 64'(Ready), 64'd1);
            chk("t1_req", 64'(imem_req), 64'd1);
        end
        tick; mem_en = 0;
        repeat (4) tick;
        chk_empty("t1_drained");

        // decode stalled: queue fills, one pop releases a credit
        do_reset;
        lat = 0; mem_en = 1; inst_ready = 0; base = acks;
        for (int k = 0; k < 5; k++) exp_q.push_back(mk(32'(4 * k)));
        repeat (4) tick;
        #1;
        chk("t2_req_full", 64'(imem_req), 64'd0);
        chk("t2_pc_full", 64'(Pc), 64'd16);
        chk("t2_req_count", 64'(acks - base), 64'd4);
        tick; #1;
        chk("t2_req_full2", 64'(imem_req), 64'd0);
        tick; inst_ready = 1; #1;
        chk("t2_credit_req", 64'(imem_req), 64'd1);
        chk("t2_credit_addr", 64'(imem_addr), 64'd16);
        tick; mem_en = 0;
        repeat (5) tick;
        chk_empty("t2_drained");

        // 3-cycle memory latency
        do_reset;
        lat = 3; mem_en = 1; inst_ready = 1;
        for (int k = 0; k < 3; k++) exp_q.push_back(mk(32'(4 * k)));
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) tick;
            #1;
            chk("t3_addr", 64'(imem_addr), 64'(4 * ((k - 1) / 4)));
            chk("t3_ready", 64'(Ready), 64'((k - 1) % 4 == 0));
            chk("t3_valid", 64'(inst_valid), 64'(k >= 5 && (k - 1) % 4 == 0));
        end
        tick; mem_en = 0;
        repeat (3) tick;
        chk_empty("t3_drained");

        // redirect while waiting on addr 8: queue flushed, ack drained, refetch 0x400
        do_reset;
        lat = 3; mem_en = 1;
        exp_q.push_back(mk(32'h400));
        for (int k = 1; k <= 18; k++) begin
            if (k > 1) tick;
            redirect = k == 10;
            redirect_pc = 32'h400;
            inst_ready = k >= 11;
            mem_en = k <= 16;
            #1;
            if (k == 10) chk("t4_wait_addr", 64'(imem_addr), 64'd8);
            if (k == 11) begin
                chk("t4_flush_valid", 64'(inst_valid), 64'd0);
                chk("t4_drop_addr", 64'(imem_addr), 64'd8);
                chk("t4_drop_req", 64'(imem_req), 64'd1);
                chk("t4_drop_ready", 64'(Ready), 64'd0);
                chk("t4_pc", 64'(Pc), 64'h400);
            end
            if (k == 12) chk("t4_drain_ack", 64'(imem_ack), 64'd1);
            if (k == 13) begin
                chk("t4_discard_valid", 64'(inst_valid), 64'd0);
                chk("t4_new_req", 64'(imem_req), 64'd1);
                chk("t4_new_addr", 64'(imem_addr), 64'h400);
            end
            if (k == 17) chk("t4_first_pc", 64'(inst_pc), 64'h400);
        end
        repeat (3) tick;
        chk_empty("t4_drained");

        // redirect coinciding with ack and pop, two entries queued
        do_reset;
        lat = 1; mem_en = 1;
        exp_q.push_back(mk(32'h0));
        exp_q.push_back(mk(32'h800));
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) tick;
            redirect = k == 6;
            redirect_pc = 32'h800;
            inst_ready = k >= 6;
            mem_en = k <= 8;
            #1;
            if (k == 6) begin
                chk("t5_ack", 64'(imem_ack), 64'd1);
                chk("t5_valid_before", 64'(inst_valid), 64'd1);
            end
            if (k == 7) begin
                chk("t5_valid_after", 64'(inst_valid), 64'd0);
                chk("t5_pc", 64'(Pc), 64'h800);
                chk("t5_req", 64'(imem_req), 64'd1);
                chk("t5_addr", 64'(imem_addr), 64'h800);
            end
            if (k == 8) chk("t5_still_empty", 64'(inst_valid), 64'd0);
            if (k == 9) chk("t5_new_inst_pc", 64'(inst_pc), 64'h800);
        end
        repeat (2) tick;
        chk_empty("t5_drained");

        // reset low during WAIT with an ack in the same cycle
        do_reset;
        lat = 1; mem_en = 1;
        tick; reset = 0; #1;
        chk("t6_ack_in_wait", 64'(imem_ack), 64'd1);
        chk("t6_wait_ready", 64'(Ready), 64'd0);
        tick; #1;
        chk_reset_vals("t6");

        // PC wraps past the top of the address space
        do_reset;
        lat = 0; mem_en = 1; inst_ready = 1;
        redirect = 1; redirect_pc = 32'hFFFFFFF8;
        exp_q.push_back(mk(32'hFFFFFFF8));
        exp_q.push_back(mk(32'hFFFFFFFC));
        exp_q.push_back(mk(32'h0));
        #1;
        chk("t7_no_req_on_redirect", 64'(imem_req), 64'd0);
        tick; redirect = 0; #1;
        chk("t7_addr0", 64'(imem_addr), 64'hFFFFFFF8);
        tick; #1;
        chk("t7_pc1", 64'(Pc), 64'hFFFFFFFC);
        tick; #1;
        chk("t7_pc_wrap", 64'(Pc), 64'd0);
        chk("t7_addr_wrap", 64'(imem_addr), 64'd0);
        tick; mem_en = 0;
        repeat (3) tick;
        chk_empty("t7_drained");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the pipelined successor of the single-cycle MIPS core. It owns the program counter, issues one-outstanding-request fetches to instruction memory over a req/ack handshake, buffers returned words in a DEPTH-entry queue, and hands {instruction, PC} pairs to decode with valid/ready flow control. Branch and jump redirects from execute flush the queue and discard any in-flight response.

## Interface
- XLEN, 32, width of PC, address and instruction.
- DEPTH, 4, queue entries; power of two, ≥2.
- RESET_PC, 0, first fetch address after reset.
- PC_STEP, 4, PC increment per sequential fetch.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  XLEN  fetch address; stable while imem_req=1.
- imem_ack  in  1  response valid; may assert in the same cycle as imem_req.
- imem_rdata  in  XLEN  instruction word, sampled when imem_ack=1.
- redirect  in  1  one-cycle pulse: flush and refetch from redirect_pc.
- redirect_pc  in  XLEN  new fetch PC, sampled when redirect=1.
- inst_valid  out  1  queue head valid.
- inst  out  XLEN  queue head instruction.
- inst_pc  out  XLEN  PC of queue head.
- inst_ready  in  1  decode accepts head; pop when inst_valid & inst_ready.
- Pc  out  XLEN  next fetch PC (fetch_pc register).
- Ready  out  1  no request outstanding (state IDLE).

## Operation
- Registers: fetch_pc, req_addr, queue (DEPTH × {inst, pc}), wr/rd pointers with wrap bit, state.
- States: IDLE (no request), WAIT (request outstanding, response kept), DROP (request outstanding, response discarded).
- IDLE: if count < DEPTH and no redirect, assert imem_req, imem_addr=fetch_pc; req_addr←fetch_pc, fetch_pc←fetch_pc+PC_STEP (mod 2^XLEN); if imem_ack same cycle, push and stay IDLE, else go WAIT.
- Credit rule: request issues only if count (after this cycle's pop) < DEPTH; queue never overflows.
- WAIT: imem_req=1, imem_addr=req_addr. On ack: push {imem_rdata, req_addr}, go IDLE. On redirect without ack: go DROP. Redirect with ack: response discarded, go IDLE.
- DROP: imem_req=1, imem_addr=req_addr (handshake never abandoned). On ack: discard, go IDLE. Further redirects stay in DROP.
- Redirect (any state): queue cleared, fetch_pc←redirect_pc; no new request issued in the redirect cycle. Redirect beats simultaneous pop and push.
- Push and pop same cycle: both occur, count unchanged.
- Reset low at any clock edge: queue empty, state IDLE, fetch_pc←RESET_PC; in-flight ack ignored.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, Pc=RESET_PC, Ready=1.
- First cycle with reset high: imem_req=1, imem_addr=RESET_PC.
- Ack in cycle N → inst_valid=1 in cycle N+1 (1-cycle min latency).
- Zero-wait memory, inst_ready held 1: one instruction per cycle sustained.
- Redirect in cycle N → inst_valid=0 in N+1; first request to redirect_pc in N+1 (IDLE) or the cycle after the draining ack (DROP).
- inst, inst_pc driven from queue head register; no combinational path from imem_rdata to inst.
- Ready is a registered-state decode; imem_req/imem_addr depend combinationally only on state, count, pop, redirect.

## Structure
- Shared package fetch_pkg: fetch_state_e {IDLE, WAIT, DROP}, default XLEN/PC_STEP/RESET_PC constants, {inst, pc} entry struct.
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO with push, pop, flush, count, empty/full; fetch_queue holds the FSM and PC logic.

## Test plan
- Reset then zero-wait memory (ack same cycle, rdata=addr^32'hFFFF0000), inst_ready=1 → inst_pc sequence 0,4,8,12… on consecutive cycles from cycle 2; Ready stays 1.
- inst_ready=0, DEPTH=4 → exactly 4 requests (addr 0,4,8,12), imem_req=0 afterwards, Pc=16; one pop → next request to 16.
- Memory with 3-cycle ack latency → imem_addr stable for 3 cycles, Ready=0 during wait, one instruction per 4 cycles.
- Redirect to 32'h400 while WAIT on addr 8 → ack for 8 discarded, queue empty, next request 32'h400, first inst_pc=32'h400.
- Redirect coinciding with ack and pop, queue holding 2 entries → inst_valid=0 next cycle, nothing pushed, Pc=redirect_pc.
- Reset asserted low during WAIT with ack in the same cycle → all outputs at reset values next cycle, no entry pushed; fetch_pc near 32'hFFFFFFFC with PC_STEP=4 wraps to 0.
